oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA engine and CPU bus gate sitting directly downstream of `cpu`, between its external bus (`address_out`/`data_out`/`cpu_wr`/`data_in`) and the memory/OAM fabric. It owns register FF46. A write there copies 160 bytes from `{src,8'h00}` into OAM, one byte per M-cycle. During the copy it blocks CPU access to the shared memory bus, while HRAM stays reachable through a dedicated port.

## Interface
Parameters:
- `OAM_LEN`, 160: bytes per transfer.
- `DMA_REG_ADDR`, 16'hFF46: address of the DMA source register.

Ports:
- `clk` in 1: T-cycle clock, shared with `cpu`.
- `rst` in 1: reset, asynchronous, active-low.
- `t_cycle` in 2: current T-phase from `cpu`; 0 starts an M-cycle.
- `cpu_addr` in 16: CPU address (`address_out`).
- `cpu_wr` in 1: CPU write enable.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: read data returned to the CPU (`data_in`).
- `mem_addr` out 16: shared memory bus address.
- `mem_wr` out 1: shared memory bus write enable.
- `mem_wdata` out 8: shared memory bus write data.
- `mem_rdata` in 8: shared memory bus read data.
- `hram_addr` out 7: HRAM offset (FF80–FFFE).
- `hram_wr` out 1: HRAM write enable.
- `hram_wdata` out 8: HRAM write data.
- `hram_rdata` in 8: HRAM read data.
- `oam_addr` out 8: OAM index being written, 0–159.
- `oam_wr` out 1: OAM write strobe, one clock wide.
- `oam_wdata` out 8: OAM write data.
- `dma_active` out 1: high in START and XFER.

## Operation
- Reset values:
  - State IDLE; `src` register = 8'hFF; `idx` = 0.
  - All write strobes low; `dma_active` 0.
  - `mem_addr`, `oam_addr` and data outputs are 0.
  - `cpu_rdata` = 8'hFF.
- Reset is asynchronous. Asserting it mid-transfer aborts the transfer immediately; no further `oam_wr` is issued.
- Register write: `cpu_wr`=1 and `cpu_addr`==FF46, sampled at `t_cycle`==3.
  - Latch `src` <= `cpu_wdata`, `idx` <= 0, next state START.
  - This applies in any state, including a restart during XFER.
- Register read: `cpu_addr`==FF46 with `cpu_wr`=0 returns `src` in any state.
- Source mapping: if `src` >= 8'hE0, the effective high byte is `src`-8'h20 (echo onto WRAM). Otherwise it is `src` unchanged.
- State machine:
  - IDLE: wait for a register write.
  - START: one full M-cycle of setup; the CPU bus is not gated; then XFER.
  - XFER: each M-cycle transfers byte `idx` (see Timing).
    - After the write with `idx`==OAM_LEN-1, go to IDLE.
    - Otherwise `idx` <= `idx`+1.
- Bus gating:
  - In XFER, `mem_*` is driven by the engine and `mem_wr`=0.
  - In XFER, CPU reads outside FF80–FFFE and FF46 return 8'hFF; CPU writes there are dropped.
  - In IDLE/START, `mem_*` passes through from `cpu_*` combinationally.
  - CPU accesses to FF80–FFFE always go to the `hram_*` port, in every state.
  - `hram_addr` = `cpu_addr[6:0]`; `hram_wr` = `cpu_wr`.
  - Those accesses never touch `mem_*`.
  - FFFF (IE) is never treated as HRAM; it passes through like any other non-HRAM address.

## Timing
- XFER M-cycle, byte `idx`:
  - t0–t3: `mem_addr` = {eff_src, `idx`}.
  - At t3: `mem_rdata` is registered.
  - On the following t0 edge: `oam_wr`=1 for one clock, with `oam_addr`=`idx` and `oam_wdata`=the registered byte.
- Latency:
  - First OAM write: 2 M-cycles (8 clocks) after the register-write sample edge.
  - Last OAM write: OAM_LEN+1 M-cycles after that edge.
- `dma_active` timing:
  - Rises on the clock after the register-write sample edge.
  - Falls on the same edge as the final `oam_wr` pulse.
- A restart during XFER:
  - Any byte already captured is still written that cycle.
  - The new transfer then starts at `idx` 0 after a fresh START.
- If `t_cycle` is not 0 when START is entered, the engine waits for the next `t_cycle`==0 before counting the START M-cycle.

## Structure
- In `common_defs.vh`:
  - State encodings `DMA_IDLE`, `DMA_START`, `DMA_XFER`.
  - HRAM bounds `HRAM_LO`=16'hFF80 and `HRAM_HI`=16'hFFFE.
  - `DMA_REG_ADDR`.
- One sub-module is natural: `bus_gate`, a combinational mux for the CPU/HRAM/mem paths, selected by `dma_xfer`.
- Sequencer, counter and source register stay in `oam_dma`.

## Test plan
- Reset mid-XFER at `idx`=40: outputs return to reset values asynchronously; `dma_active`=0; no `oam_wr` after the reset edge.
- Write 8'hC1 to FF46: OAM gets 160 writes, `oam_addr` 0..159 with data from C100..C19F. The first write comes 8 clocks after the sample edge; `dma_active` is high for 161 M-cycles.
- During XFER, CPU read of C000 returns 8'hFF, and a CPU write to C000 never asserts `mem_wr`. A CPU write of 8'h5A to FF90 sets `hram_wr`=1 with `hram_addr`=7'h10.
- Write 8'hE2 to FF46: `mem_addr` sweeps C200..C29F; a read of FF46 returns 8'hE2.
- Restart with 8'hD0 at `idx`=100: byte 100 from the old source is still written, then one START M-cycle, then `idx` 0 is sourced from D000; 160 further writes follow.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine: state encoding, HRAM window,
// default register address and source-page helper functions.
package oam_dma_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      DMA_IDLE  = 2'd0,
      DMA_START = 2'd1,
      DMA_XFER  = 2'd2
   } dma_state_t;

   // HRAM window; FFFF (IE) is deliberately outside it
   localparam logic [15:0] HRAM_LO = 16'hFF80;
   localparam logic [15:0] HRAM_HI = 16'hFFFE;

   // Default location of the DMA source register and transfer length
   localparam logic [15:0] DMA_REG_ADDR_DEF = 16'hFF46;
   localparam int          OAM_LEN_DEF      = 160;

   // T-phase that closes an M-cycle (CPU bus sample point)
   localparam logic [1:0] T_FIRST = 2'd0;
   localparam logic [1:0] T_LAST  = 2'd3;

   // Source pages E0..FF mirror WRAM, so fold them back down by 0x20 pages
   function automatic logic [7:0] eff_src_hi(input logic [7:0] src);
      return (src >= 8'hE0) ? (src - 8'h20) : src;
   endfunction

   // True for CPU addresses served by the dedicated HRAM port
   function automatic logic in_hram(input logic [15:0] addr);
      return (addr >= HRAM_LO) && (addr <= HRAM_HI);
   endfunction

endpackage

// File: rtl/oam_dma_bus_gate.sv
// Combinational steering of CPU accesses between the shared memory bus,
// the HRAM port and the DMA source register. While a transfer is in
// XFER the engine owns the memory bus and the CPU only sees HRAM and FF46.
module oam_dma_bus_gate
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF
) (
   input  logic        hold,        // force reset values while in reset
   input  logic        dma_xfer,    // engine owns the memory bus
   input  logic [15:0] dma_addr,    // engine source address
   input  logic [7:0]  src_val,     // current DMA source register
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [6:0]  hram_addr,
   output logic        hram_wr,
   output logic [7:0]  hram_wdata,
   input  logic [7:0]  hram_rdata
);

   logic is_hram;
   logic is_reg;

   assign is_hram = in_hram(cpu_addr);
   assign is_reg  = (cpu_addr == DMA_REG_ADDR);

   // Route CPU reads/writes to memory, HRAM or the register; gate during XFER
   always_comb begin
      cpu_rdata  = 8'hFF;
      mem_addr   = cpu_addr;
      mem_wr     = 1'b0;
      mem_wdata  = cpu_wdata;
      hram_addr  = cpu_addr[6:0];
      hram_wr    = 1'b0;
      hram_wdata = cpu_wdata;

      if (hold) begin
         mem_addr   = 16'h0000;
         mem_wdata  = 8'h00;
         hram_addr  = 7'h00;
         hram_wdata = 8'h00;
      end else begin
         if (dma_xfer) begin
            // Engine drives the bus read-only; CPU writes are dropped
            mem_addr  = dma_addr;
            mem_wdata = 8'h00;
         end else begin
            // HRAM and register writes never reach the shared bus
            mem_wr = cpu_wr && !is_hram && !is_reg;
         end

         if (is_hram) begin
            hram_wr   = cpu_wr;
            cpu_rdata = hram_rdata;
         end else if (is_reg) begin
            cpu_rdata = src_val;
         end else if (!dma_xfer) begin
            cpu_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: owns the source register, sequences IDLE -> START -> XFER
// and copies OAM_LEN bytes from {src,8'h00} into OAM, one per M-cycle.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int          OAM_LEN      = OAM_LEN_DEF,
   parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  t_cycle,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic [6:0]  hram_addr,
   output logic        hram_wr,
   output logic [7:0]  hram_wdata,
   input  logic [7:0]  hram_rdata,
   output logic [7:0]  oam_addr,
   output logic        oam_wr,
   output logic [7:0]  oam_wdata,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

   dma_state_t state_reg, state_next;
   logic [7:0] src_reg, src_next;
   logic [7:0] idx_reg, idx_next;
   logic       start_seen_reg, start_seen_next;
   logic       oam_wr_reg, oam_wr_next;
   logic [7:0] oam_addr_reg, oam_addr_next;
   logic [7:0] oam_wdata_reg, oam_wdata_next;

   logic        reg_write;
   logic        last_phase;
   logic        dma_xfer;
   logic [15:0] dma_addr;

   assign last_phase = (t_cycle == T_LAST);
   assign reg_write  = cpu_wr && (cpu_addr == DMA_REG_ADDR) && last_phase;
   assign dma_xfer   = (state_reg == DMA_XFER);
   assign dma_addr   = {eff_src_hi(src_reg), idx_reg};

   assign dma_active = (state_reg != DMA_IDLE);
   assign oam_wr     = oam_wr_reg;
   assign oam_addr   = oam_addr_reg;
   assign oam_wdata  = oam_wdata_reg;

   // State and datapath registers; reset aborts any transfer at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= DMA_IDLE;
         src_reg        <= 8'hFF;
         idx_reg        <= 8'h00;
         start_seen_reg <= 1'b0;
         oam_wr_reg     <= 1'b0;
         oam_addr_reg   <= 8'h00;
         oam_wdata_reg  <= 8'h00;
      end else begin
         state_reg      <= state_next;
         src_reg        <= src_next;
         idx_reg        <= idx_next;
         start_seen_reg <= start_seen_next;
         oam_wr_reg     <= oam_wr_next;
         oam_addr_reg   <= oam_addr_next;
         oam_wdata_reg  <= oam_wdata_next;
      end
   end

   // Next-state: START waits for an aligned M-cycle, XFER moves one byte
   // per M-cycle, and a register write restarts from any state
   always_comb begin
      state_next      = state_reg;
      src_next        = src_reg;
      idx_next        = idx_reg;
      start_seen_next = (state_reg == DMA_START) ? start_seen_reg : 1'b0;
      oam_wr_next     = 1'b0;
      oam_addr_next   = oam_addr_reg;
      oam_wdata_next  = oam_wdata_reg;

      case (state_reg)
         DMA_IDLE: begin
         end
         DMA_START: begin
            // Count the setup M-cycle only once it began on a t0 phase
            if (t_cycle == T_FIRST) begin
               start_seen_next = 1'b1;
            end
            if (last_phase && start_seen_reg) begin
               state_next = DMA_XFER;
            end
         end
         DMA_XFER: begin
            // Capture the byte at t3 and strobe it into OAM on the same edge
            if (last_phase) begin
               oam_wr_next    = 1'b1;
               oam_addr_next  = idx_reg;
               oam_wdata_next = mem_rdata;
               if (idx_reg == LAST_IDX) begin
                  state_next = DMA_IDLE;
                  idx_next   = 8'h00;
               end else begin
                  idx_next = idx_reg + 8'h01;
               end
            end
         end
         default: begin
            state_next = DMA_IDLE;
         end
      endcase

      // A register write wins over everything; an in-flight byte still lands
      if (reg_write) begin
         src_next        = cpu_wdata;
         idx_next        = 8'h00;
         start_seen_next = 1'b0;
         state_next      = DMA_START;
      end
   end

   oam_dma_bus_gate #(
      .DMA_REG_ADDR (DMA_REG_ADDR)
   ) u_bus_gate (
      .hold       (~rst),
      .dma_xfer   (dma_xfer),
      .dma_addr   (dma_addr),
      .src_val    (src_reg),
      .cpu_addr   (cpu_addr),
      .cpu_wr     (cpu_wr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .hram_addr  (hram_addr),
      .hram_wr    (hram_wr),
      .hram_wdata (hram_wdata),
      .hram_rdata (hram_rdata)
   );

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: bus-gate vector table, directed
// transfer/restart/reset sequences and randomized source pages.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  t_cycle = 2'd0;
   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [6:0]  hram_addr;
   logic        hram_wr;
   logic [7:0]  hram_wdata;
   logic [7:0]  hram_rdata;
   logic [7:0]  oam_addr;
   logic        oam_wr;
   logic [7:0]  oam_wdata;
   logic        dma_active;

   logic [7:0] mem_image [0:65535];
   assign mem_rdata = mem_image[mem_addr];

   oam_dma dut (
      .clk        (clk),
      .rst        (rst),
      .t_cycle    (t_cycle),
      .cpu_addr   (cpu_addr),
      .cpu_wr     (cpu_wr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_wr     (mem_wr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .hram_addr  (hram_addr),
      .hram_wr    (hram_wr),
      .hram_wdata (hram_wdata),
      .hram_rdata (hram_rdata),
      .oam_addr   (oam_addr),
      .oam_wr     (oam_wr),
      .oam_wdata  (oam_wdata),
      .dma_active (dma_active)
   );

   always #5 clk = ~clk;

   // T-phase counter as the CPU would present it
   initial begin
      forever begin
         @(posedge clk);
         #1 t_cycle = t_cycle + 2'd1;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      int         cyc;
   } wr_t;
   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   wr_t  oam_q[$];
   exp_t exp_q[$];
   int   act_cnt = 0;

   // Observe OAM writes and dma_active away from the active edge
   always @(negedge clk) begin
      if (oam_wr === 1'b1) oam_q.push_back('{oam_addr, oam_wdata, cyc});
      if (dma_active === 1'b1) act_cnt = act_cnt + 1;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Write the source register so that it is sampled on a t3 edge
   task automatic reg_write(input logic [7:0] v, output int samp);
      int guard = 0;
      @(negedge clk);
      while (t_cycle != 2'd3 && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 8) check("phase_align", 64'(t_cycle), 64'd3);
      act_cnt   = 0;
      cpu_addr  = 16'hFF46;
      cpu_wr    = 1'b1;
      cpu_wdata = v;
      @(negedge clk);
      samp      = cyc;
      cpu_wr    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 8'h00;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (dma_active === 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("dma_done_in_budget", 64'(dma_active), 64'd0);
      @(negedge clk);
   endtask

   task automatic wait_writes(input int count, input int budget);
      int n = 0;
      while (oam_q.size() < count && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("writes_reached", 64'(oam_q.size() >= count), 64'd1);
   endtask

   // Reference: byte i of a transfer comes from page src (echo E0+ folded to C0+)
   task automatic expect_run(input logic [7:0] src, input int first, input int count);
      int page = int'(src);
      if (page >= 224) page = page - 32;
      for (int i = first; i < first + count; i++) begin
         exp_q.push_back('{8'(i), mem_image[page * 256 + i]});
      end
   endtask

   task automatic compare_q(input string name);
      int n;
      check({name, "_count"}, 64'(oam_q.size()), 64'(exp_q.size()));
      n = (oam_q.size() < exp_q.size()) ? oam_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_byte%0d", name, i),
               {48'h0, oam_q[i].addr, oam_q[i].data},
               {48'h0, exp_q[i].addr, exp_q[i].data});
      end
      $display("[TB] transfer %s: %0d writes seen, %0d expected", name, oam_q.size(), exp_q.size());
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [7:0]  wdata;
      logic [15:0] e_maddr;
      logic        e_mwr;
      logic        e_hwr;
      logic [7:0]  e_rdata;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int samp;
      int samp2;
      int k;
      int n_before;
      logic [7:0] rsrc;

      #300000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int samp;
      int samp2;
      int k;
      int n_before;
      logic [7:0] rsrc;

      vecs[0] = '{16'hC000, 1'b0, 8'h00, 16'hC000, 1'b0, 1'b0, 8'h3C};
      vecs[1] = '{16'hC000, 1'b1, 8'h55, 16'hC000, 1'b1, 1'b0, 8'h3C};
      vecs[2] = '{16'hFF80, 1'b1, 8'h11, 16'hFF80, 1'b0, 1'b1, 8'hA7};
      vecs[3] = '{16'hFFFE, 1'b0, 8'h00, 16'hFFFE, 1'b0, 1'b0, 8'hA7};
      vecs[4] = '{16'hFFFF, 1'b0, 8'h00, 16'hFFFF, 1'b0, 1'b0, 8'h1F};
      vecs[5] = '{16'hFFFF, 1'b1, 8'h22, 16'hFFFF, 1'b1, 1'b0, 8'h1F};
      vecs[6] = '{16'hFF7F, 1'b0, 8'h00, 16'hFF7F, 1'b0, 1'b0, 8'h77};
      vecs[7] = '{16'hFF46, 1'b0, 8'h00, 16'hFF46, 1'b0, 1'b0, 8'hFF};
      vecs[8] = '{16'hFE00, 1'b1, 8'h99, 16'hFE00, 1'b1, 1'b0, 8'h5E};

      for (int a = 0; a < 65536; a++) mem_image[a] = 8'($urandom);
      mem_image[16'hC000] = 8'h3C;
      mem_image[16'hFFFF] = 8'h1F;
      mem_image[16'hFF7F] = 8'h77;
      mem_image[16'hFE00] = 8'h5E;
      hram_rdata = 8'hA7;
      cpu_addr   = 16'hFF46;
      cpu_wr     = 1'b0;
      cpu_wdata  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dma_active", 64'(dma_active), 64'd0);
      check("rst_oam_wr", 64'(oam_wr), 64'd0);
      check("rst_oam_addr", 64'(oam_addr), 64'd0);
      check("rst_oam_wdata", 64'(oam_wdata), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wr", 64'(mem_wr), 64'd0);
      check("rst_cpu_rdata", 64'(cpu_rdata), 64'hFF);
      rst = 1'b1;

      // Bus gate in IDLE
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         cpu_addr  = vecs[i].addr;
         cpu_wr    = vecs[i].wr;
         cpu_wdata = vecs[i].wdata;
         #1;
         check($sformatf("idle_vec%0d", i),
               {38'h0, mem_addr, mem_wr, hram_wr, cpu_rdata},
               {38'h0, vecs[i].e_maddr, vecs[i].e_mwr, vecs[i].e_hwr, vecs[i].e_rdata});
         check($sformatf("idle_vec%0d_hram_addr", i), 64'(hram_addr), 64'(vecs[i].addr[6:0]));
         $display("[TB] vec %0d addr=%h wr=%0d mem_addr=%h mem_wr=%0d hram_wr=%0d rdata=%h",
                  i, cpu_addr, cpu_wr, mem_addr, mem_wr, hram_wr, cpu_rdata);
      end
      cpu_wr   = 1'b0;
      cpu_addr = 16'h0000;

      // Transfer from C1 with CPU gating checks mid-XFER
      oam_q.delete();
      exp_q.delete();
      expect_run(8'hC1, 0, 160);
      reg_write(8'hC1, samp);
      repeat (20) @(negedge clk);
      k = cyc - samp;
      cpu_addr = 16'hC000;
      #1;
      check("xfer_read_c000", 64'(cpu_rdata), 64'hFF);
      check("xfer_mem_addr", 64'(mem_addr), 64'(16'hC100 + (k - 4) / 4));
      @(negedge clk);
      cpu_wr = 1'b1;
      cpu_wdata = 8'hAA;
      #1;
      check("xfer_write_c000_mem_wr", 64'(mem_wr), 64'd0);
      @(negedge clk);
      cpu_addr = 16'hFF90;
      cpu_wdata = 8'h5A;
      #1;
      check("xfer_hram_wr", 64'(hram_wr), 64'd1);
      check("xfer_hram_addr", 64'(hram_addr), 64'h10);
      check("xfer_hram_wdata", 64'(hram_wdata), 64'h5A);
      check("xfer_hram_mem_wr", 64'(mem_wr), 64'd0);
      @(negedge clk);
      cpu_wr = 1'b0;
      cpu_addr = 16'hFF46;
      #1;
      check("xfer_read_ff46", 64'(cpu_rdata), 64'hC1);
      @(negedge clk);
      cpu_addr = 16'h0000;
      wait_idle(900);
      compare_q("c1");
      if (oam_q.size() == 160) begin
         check("c1_first_latency", 64'(oam_q[0].cyc - samp), 64'd8);
         check("c1_last_latency", 64'(oam_q[159].cyc - samp), 64'd644);
      end else begin
         check("c1_write_count_for_timing", 64'(oam_q.size()), 64'd160);
      end
      check("c1_active_clocks", 64'(act_cnt), 64'd644);

      // Echo source E2 folds onto C2
      oam_q.delete();
      exp_q.delete();
      expect_run(8'hE2, 0, 160);
      reg_write(8'hE2, samp);
      repeat (30) @(negedge clk);
      k = cyc - samp;
      cpu_addr = 16'hFF46;
      #1;
      check("e2_read_ff46", 64'(cpu_rdata), 64'hE2);
      check("e2_mem_addr", 64'(mem_addr), 64'(16'hC200 + (k - 4) / 4));
      @(negedge clk);
      cpu_addr = 16'h0000;
      wait_idle(900);
      compare_q("e2");

      // Restart with D0 while byte 100 of a C3 transfer is in flight
      oam_q.delete();
      exp_q.delete();
      expect_run(8'hC3, 0, 101);
      expect_run(8'hD0, 0, 160);
      reg_write(8'hC3, samp);
      wait_writes(100, 1000);
      reg_write(8'hD0, samp2);
      wait_idle(900);
      compare_q("restart");
      if (oam_q.size() == 261) begin
         check("restart_inflight_edge", 64'(oam_q[100].cyc - samp2), 64'd0);
         check("restart_first_new_latency", 64'(oam_q[101].cyc - samp2), 64'd8);
      end else begin
         check("restart_count_for_timing", 64'(oam_q.size()), 64'd261);
      end

      // Randomized source pages
      for (int r = 0; r < 3; r++) begin
         rsrc = 8'($urandom_range(0, 255));
         if (r == 0) rsrc = 8'($urandom_range(224, 255));
         oam_q.delete();
         exp_q.delete();
         expect_run(rsrc, 0, 160);
         reg_write(rsrc, samp);
         wait_idle(900);
         compare_q($sformatf("rand_%h", rsrc));
         if (oam_q.size() > 0)
            check($sformatf("rand_%h_first_latency", rsrc), 64'(oam_q[0].cyc - samp), 64'd8);
      end

      // Asynchronous reset at idx 40 aborts the transfer
      oam_q.delete();
      reg_write(8'hC1, samp);
      wait_writes(40, 1000);
      cpu_addr = 16'hC000;
      #2 rst = 1'b0;
      #1;
      check("abort_dma_active", 64'(dma_active), 64'd0);
      check("abort_oam_wr", 64'(oam_wr), 64'd0);
      check("abort_oam_addr", 64'(oam_addr), 64'd0);
      check("abort_oam_wdata", 64'(oam_wdata), 64'd0);
      check("abort_mem_addr", 64'(mem_addr), 64'd0);
      check("abort_cpu_rdata", 64'(cpu_rdata), 64'hFF);
      n_before = oam_q.size();
      repeat (12) @(negedge clk);
      rst = 1'b1;
      cpu_addr = 16'hFF46;
      #1;
      check("abort_src_reset", 64'(cpu_rdata), 64'hFF);
      repeat (700) @(negedge clk);
      check("abort_no_more_writes", 64'(oam_q.size()), 64'(n_before));
      check("abort_stays_idle", 64'(dma_active), 64'd0);
      $display("[TB] abort: %0d writes before reset, %0d after", n_before, oam_q.size() - n_before);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
